// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and backing-memory signals of the unified memory arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until their one-cycle ready pulse.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // fetch side
  logic                    i_req;
  logic [ADDR_WIDTH-1:0]   i_addr;
  logic [DATA_WIDTH-1:0]   i_rdata;
  logic                    i_ready;
  // data side
  logic                    d_req;
  logic                    d_we;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic [DATA_WIDTH/8-1:0] d_be;
  logic [DATA_WIDTH-1:0]   d_rdata;
  logic                    d_ready;
  // backing memory
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_rvalid;
  logic                    err;

  // arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_rvalid,
    output i_rdata, i_ready, d_rdata, d_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be, err
  );

  // environment view: requesters plus memory
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_rvalid,
    input  i_rdata, i_ready, d_rdata, d_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch (read-only) and data (load/store), D-priority with anti-starvation.
// Latency: grant in IDLE at cycle 0, mem_req at 1, earliest mem_rvalid at 2, ready at 3; one transaction in flight.
// Backpressure: requests wait while busy; a transaction with no mem_rvalid for TIMEOUT WAIT cycles completes with err.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state_q;
  logic                    owner_d_q;   // 1: data side owns the transaction
  logic [SW-1:0]           streak_q;
  logic [TW-1:0]           tmo_q;

  logic                    i_ready_q;
  logic                    d_ready_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   i_rdata_q;
  logic [DATA_WIDTH-1:0]   d_rdata_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH/8-1:0] mem_be_q;

  logic win_d;
  logic win_i;

  // D wins a tie unless it has already taken MAX_D_STREAK grants in a row over a waiting fetch
  always_comb begin
    win_d = bus.d_req & (~bus.i_req | (streak_q != STREAK_MAX));
    win_i = bus.i_req & ~win_d;
  end

  // Transaction FSM; every output is a register updated on the transition into its state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_d) begin
            state_q     <= ISSUE;
            owner_d_q   <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            mem_be_q    <= bus.d_be;
            if (bus.i_req && (streak_q != STREAK_MAX)) begin
              streak_q <= streak_q + SW'(1);
            end
          end else if (win_i) begin
            state_q     <= ISSUE;
            owner_d_q   <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= '1;
            streak_q    <= '0;
          end
          // No fetch waiting means D priority has cost fetch nothing
          if (!bus.i_req) begin
            streak_q <= '0;
          end
        end
        ISSUE: begin
          mem_req_q <= 1'b0;
          tmo_q     <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            // read data is latched for stores too, whatever the memory drives
            if (owner_d_q) begin
              d_rdata_q <= bus.mem_rdata;
              d_ready_q <= 1'b1;
            end else begin
              i_rdata_q <= bus.mem_rdata;
              i_ready_q <= 1'b1;
            end
            state_q <= RESP;
          end else if (tmo_q == TMO_LAST) begin
            if (owner_d_q) begin
              d_rdata_q <= '0;
              d_ready_q <= 1'b1;
            end else begin
              i_rdata_q <= '0;
              i_ready_q <= 1'b1;
            end
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RESP: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          err_q     <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_ready   = i_ready_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule
